// File: rtl/fc_pkg.sv
// Shared types and helpers for the fc_layer chain glue logic.
package fc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_DS,
    LAUNCH,
    WAIT_ACK
  } state_t;

  // Address width that never collapses to zero bits for a single-element buffer.
  function automatic int unsigned addr_w(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fc_layer_link.sv
// Streams one upstream fc_layer output vector into the downstream input buffer
// and hands off with a single start pulse once the downstream layer is free.
module fc_layer_link
  import fc_pkg::*;
#(
  parameter int unsigned output_size   = 784,
  parameter int unsigned datatype_size = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_func_valid,
  input  logic [datatype_size-1:0]         i_func_data,
  output logic                             o_busy,
  output logic                             o_ibuf_we,
  output logic [datatype_size-1:0]         o_ibuf_wr_data,
  output logic [addr_w(output_size)-1:0]   o_ibuf_addr,
  output logic                             o_start,
  input  logic                             i_next_busy,
  output logic                             o_overflow
);

  localparam int unsigned AW = addr_w(output_size);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(output_size - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          accept;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, element acceptance and the upstream back-pressure.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    o_busy     = 1'b1;
    unique case (state)
      IDLE: begin
        o_busy = i_next_busy;
        if (i_func_valid && !i_next_busy) begin
          accept = 1'b1;
          if (output_size == 1) begin
            state_next = WAIT_DS;
            cnt_next   = '0;
          end else begin
            state_next = FILL;
            cnt_next   = CW'(1);
          end
        end
      end
      FILL: begin
        o_busy = 1'b0;
        if (i_func_valid) begin
          accept = 1'b1;
          if (cnt == LAST) begin
            state_next = WAIT_DS;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      WAIT_DS:  if (!i_next_busy) state_next = LAUNCH;
      LAUNCH:   state_next = WAIT_ACK;
      WAIT_ACK: if (i_next_busy) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Registered write port, start pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      o_ibuf_we      <= 1'b0;
      o_ibuf_wr_data <= '0;
      o_ibuf_addr    <= '0;
      o_start        <= 1'b0;
      o_overflow     <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      o_ibuf_we <= accept;
      if (accept) begin
        o_ibuf_wr_data <= i_func_data;
        o_ibuf_addr    <= cnt[AW-1:0];
      end
      o_start <= (state_next == LAUNCH);
      if (i_func_valid && !accept) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_layer_link.sv
// Bench for fc_layer_link: directed vector table, corner sequences and random
// traffic against a count-based model of the fill / launch / acknowledge cycle.
module tb_fc_layer_link;

  localparam int unsigned OS = 10;

  logic       clk = 1'b0;
  logic       rst, valid, nb;
  logic [1:0] data;
  logic       busy, we, start, ovf;
  logic [1:0] wdata;
  logic [3:0] addr;

  logic       valid1, nb1;
  logic [1:0] data1;
  logic       busy1, we1, start1, ovf1;
  logic [1:0] wdata1;
  logic [0:0] addr1;

  always #5 clk = ~clk;

  fc_layer_link #(.output_size(OS), .datatype_size(2)) dut (
    .clk(clk), .rst(rst), .i_func_valid(valid), .i_func_data(data),
    .o_busy(busy), .o_ibuf_we(we), .o_ibuf_wr_data(wdata), .o_ibuf_addr(addr),
    .o_start(start), .i_next_busy(nb), .o_overflow(ovf)
  );

  fc_layer_link #(.output_size(1), .datatype_size(2)) dut1 (
    .clk(clk), .rst(rst), .i_func_valid(valid1), .i_func_data(data1),
    .o_busy(busy1), .o_ibuf_we(we1), .o_ibuf_wr_data(wdata1), .o_ibuf_addr(addr1),
    .o_start(start1), .i_next_busy(nb1), .o_overflow(ovf1)
  );

  int checks = 0;
  int failures = 0;
  int starts = 0;
  int writes = 0;

  // Model: elements in the current batch, whether the start pulse is out now,
  // whether we are waiting for downstream to acknowledge, plus expected registers.
  int         m_cnt;
  bit         m_launch, m_wait, m_ovf, m_we;
  int         m_addr;
  logic [1:0] m_data;

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       nb;
    logic       busy;
    logic       start;
    logic       we;
    logic [3:0] addr;
    logic [1:0] wd;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic v, input logic [1:0] d, input logic b, input logic r);
    valid = v; data = d; nb = b; rst = r;
    #1;
  endtask

  task automatic check_model();
    bit full;
    bit exp_busy;
    full = (m_cnt == OS);
    exp_busy = (full || m_launch || m_wait) ? 1'b1 : ((m_cnt == 0) ? nb : 1'b0);
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("start", 32'(start), 32'(m_launch));
    chk("we", 32'(we), 32'(m_we));
    if (m_we) begin
      chk("addr", 32'(addr), 32'(m_addr));
      chk("wdata", 32'(wdata), 32'(m_data));
    end
    chk("overflow", 32'(ovf), 32'(m_ovf));
    if (start) starts++;
    if (we) writes++;
  endtask

  task automatic advance();
    bit full, acc;
    if (rst) begin
      m_cnt = 0; m_launch = 0; m_wait = 0; m_ovf = 0; m_we = 0; m_addr = 0; m_data = '0;
    end else begin
      full = (m_cnt == OS);
      acc  = valid && !full && !m_launch && !m_wait && (m_cnt != 0 || !nb);
      m_we = acc;
      if (acc) begin
        m_addr = m_cnt;
        m_data = data;
      end
      if (valid && !acc) m_ovf = 1;
      if (m_launch) begin
        m_launch = 0;
        m_wait   = 1;
      end else if (m_wait) begin
        if (nb) begin
          m_wait = 0;
          m_cnt  = 0;
        end
      end else if (full && !nb) begin
        m_launch = 1;
      end
      if (acc) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [1:0] d, input logic b, input logic r);
    apply(v, d, b, r);
    check_model();
    advance();
  endtask

  task automatic idle_cycles(input int n, input logic b);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, b, 1'b0);
  endtask

  task automatic fill_batch();
    for (int i = 0; i < OS; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
  endtask

  task automatic handshake();
    idle_cycles(3, 1'b0);
    idle_cycles(2, 1'b1);
    idle_cycles(1, 1'b0);
  endtask

  initial begin
    valid1 = 1'b0; data1 = 2'd0; nb1 = 1'b0;
    apply(1'b0, 2'd0, 1'b0, 1'b1);
    advance();
    apply(1'b0, 2'd0, 1'b0, 1'b1);
    advance();
    apply(1'b0, 2'd0, 1'b0, 1'b0);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_addr", 32'(addr), 32'd0);
    chk("reset_wdata", 32'(wdata), 32'd0);
    chk("reset_start", 32'(start), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Ten back-to-back elements, then launch and acknowledge.
    for (int i = 0; i < 10; i++) begin
      vecs[i] = '{v: 1'b1, d: 2'(i % 4), nb: 1'b0, busy: 1'b0, start: 1'b0,
                  we: (i > 0), addr: (i > 0) ? 4'(i - 1) : 4'd0,
                  wd: (i > 0) ? 2'((i - 1) % 4) : 2'd0};
    end
    vecs[10] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 2'd1};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 2'd0};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0};
    vecs[14] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0};
    vecs[15] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0};
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].v, vecs[i].d, vecs[i].nb, 1'b0);
      chk("vec_busy", 32'(busy), 32'(vecs[i].busy));
      chk("vec_start", 32'(start), 32'(vecs[i].start));
      chk("vec_we", 32'(we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk("vec_addr", 32'(addr), 32'(vecs[i].addr));
        chk("vec_wdata", 32'(wdata), 32'(vecs[i].wd));
      end
      check_model();
      advance();
    end

    // Elements every third cycle.
    starts = 0; writes = 0;
    for (int k = 0; k < 30; k++) step((k % 3) == 0, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    idle_cycles(1, 1'b0);
    idle_cycles(2, 1'b1);
    idle_cycles(1, 1'b0);
    chk("gap_writes", 32'(writes), 32'd10);
    chk("gap_starts", 32'(starts), 32'd1);

    // Downstream busy for 20 cycles after the fill.
    fill_batch();
    starts = 0;
    idle_cycles(20, 1'b1);
    chk("held_no_start", 32'(starts), 32'd0);
    idle_cycles(1, 1'b0);
    apply(1'b0, 2'd0, 1'b0, 1'b0);
    chk("start_after_fall", 32'(start), 32'd1);
    check_model();
    advance();
    idle_cycles(1, 1'b0);
    idle_cycles(2, 1'b1);
    idle_cycles(1, 1'b0);

    // Extra element while waiting for downstream.
    fill_batch();
    step(1'b1, 2'd3, 1'b1, 1'b0);
    apply(1'b0, 2'd0, 1'b1, 1'b0);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_no_write", 32'(we), 32'd0);
    check_model();
    advance();
    handshake();
    fill_batch();
    handshake();
    apply(1'b0, 2'd0, 1'b0, 1'b0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    apply(1'b0, 2'd0, 1'b0, 1'b0);
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Reset after five writes, with a valid in the reset cycle.
    for (int i = 0; i < 5; i++) step(1'b1, 2'(i), 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b1);
    starts = 0; writes = 0;
    apply(1'b1, 2'd1, 1'b0, 1'b0);
    chk("rst_abort_we", 32'(we), 32'd0);
    check_model();
    advance();
    apply(1'b1, 2'd2, 1'b0, 1'b0);
    chk("restart_addr", 32'(addr), 32'd0);
    chk("restart_wdata", 32'(wdata), 32'd1);
    check_model();
    advance();
    for (int i = 2; i < 10; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    handshake();
    chk("restart_writes", 32'(writes), 32'd10);
    chk("restart_starts", 32'(starts), 32'd1);

    // Random traffic.
    begin
      logic b;
      b = 1'b0;
      for (int k = 0; k < 1500; k++) begin
        if ($urandom_range(0, 5) == 0) b = ~b;
        step($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), b,
             $urandom_range(0, 299) == 0);
      end
    end
    step(1'b0, 2'd0, 1'b0, 1'b1);

    // Single-element buffer.
    apply(1'b0, 2'd0, 1'b0, 1'b0);
    valid1 = 1'b1; data1 = 2'd2; nb1 = 1'b0;
    #1;
    chk("os1_busy_idle", 32'(busy1), 32'd0);
    @(posedge clk); #1;
    valid1 = 1'b0;
    #1;
    chk("os1_we", 32'(we1), 32'd1);
    chk("os1_addr", 32'(addr1), 32'd0);
    chk("os1_wdata", 32'(wdata1), 32'd2);
    chk("os1_no_start_with_we", 32'(start1), 32'd0);
    chk("os1_busy_wait", 32'(busy1), 32'd1);
    @(posedge clk); #1;
    chk("os1_start", 32'(start1), 32'd1);
    chk("os1_we_off", 32'(we1), 32'd0);
    @(posedge clk); #1;
    chk("os1_start_one_cycle", 32'(start1), 32'd0);
    nb1 = 1'b1;
    @(posedge clk); #1;
    nb1 = 1'b0;
    #1;
    chk("os1_back_idle", 32'(busy1), 32'd0);
    chk("os1_ovf", 32'(ovf1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fc_layer_link.md
FC_LAYER_LINK -- requirements
Module: fc_layer_link

Interface
REQ-001 SHALL have parameter output_size, default 784, meaning number of elements the upstream fc_layer produces and the downstream fc_layer input buffer holds.
REQ-002 SHALL have parameter datatype_size, default 2, meaning bits per element.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_func_valid, input, 1, upstream activation output element valid this cycle.
REQ-006 SHALL have port i_func_data, input, datatype_size, upstream activation output element (upstream o_func_data).
REQ-007 SHALL have port o_busy, output, 1, drives upstream i_next_busy.
REQ-008 SHALL have port o_ibuf_we, output, 1, downstream input buffer write enable (downstream i_ibuf_we).
REQ-009 SHALL have port o_ibuf_wr_data, output, datatype_size, downstream write data.
REQ-010 SHALL have port o_ibuf_addr, output, $clog2(output_size), downstream write address.
REQ-011 SHALL have port o_start, output, 1, one-cycle start pulse to downstream i_start.
REQ-012 SHALL have port i_next_busy, input, 1, downstream o_busy.
REQ-013 SHALL have port o_overflow, output, 1, sticky error flag: element arrived while not accepting.

Function
REQ-014 SHALL implement FSM states IDLE, FILL, WAIT_DS, LAUNCH, WAIT_ACK.
REQ-015 SHALL hold an element counter cnt of width $clog2(output_size)+1 giving the next write address.
REQ-016 IDLE: o_busy = i_next_busy; on i_func_valid with i_next_busy=0, write at addr 0, cnt<=1, go FILL (or WAIT_DS if output_size=1).
REQ-017 FILL: o_busy=0; each i_func_valid writes at addr cnt, cnt<=cnt+1; the write at addr output_size-1 moves to WAIT_DS, cnt<=0.
REQ-018 Writes SHALL be registered: o_ibuf_we/o_ibuf_wr_data/o_ibuf_addr valid exactly 1 cycle after the accepting i_func_valid cycle; o_ibuf_we=0 otherwise.
REQ-019 WAIT_DS: o_busy=1; when i_next_busy=0, go LAUNCH.
REQ-020 LAUNCH: o_start=1 for exactly this one cycle, o_busy=1, go WAIT_ACK.
REQ-021 WAIT_ACK: o_busy=1; when i_next_busy=1 (downstream accepted), go IDLE.
REQ-022 o_start SHALL never be asserted in the same cycle as o_ibuf_we; the last write always precedes o_start by at least 1 cycle.
REQ-023 i_func_valid in WAIT_DS, LAUNCH, WAIT_ACK, or in IDLE with i_next_busy=1 SHALL be dropped (no write, cnt unchanged) and SHALL set o_overflow=1 until reset.
REQ-024 Address SHALL never wrap past output_size-1; an element past the last is handled by REQ-023.
REQ-025 i_next_busy falling mid-FILL SHALL have no effect on FILL.

Reset
REQ-026 On rst=1 at a clock edge: state<=IDLE, cnt<=0, o_ibuf_we<=0, o_ibuf_wr_data<=0, o_ibuf_addr<=0, o_start<=0, o_overflow<=0; o_busy then follows i_next_busy.
REQ-027 Reset asserted mid-FILL or mid-LAUNCH SHALL abort without a further write or start pulse; partial buffer contents are discarded logically.
REQ-028 rst SHALL take priority over i_func_valid in the same cycle.

Structure
REQ-029 State enum typedef and address-width helper SHALL live in shared package fc_pkg.
REQ-030 Single flat module; no sub-module; a layer chain instantiates one fc_layer_link between each pair of fc_layer instances.

Verification (output_size=10, datatype_size=2)
REQ-031 10 consecutive valids data 0,1,2,3,0,1,2,3,0,1, i_next_busy=0 -> writes at addr 0..9 one cycle later, o_start pulse 2 cycles after last valid, o_busy=1 until i_next_busy rises.
REQ-032 Valids with gaps (every 3rd cycle) -> same 10 writes, addresses contiguous, no extra start.
REQ-033 Fill completes with i_next_busy=1 held 20 cycles -> o_start=0 throughout, pulses 1 cycle after i_next_busy falls.
REQ-034 11th valid during WAIT_DS -> no write, o_overflow=1, stays 1 until rst.
REQ-035 rst after 5 writes, then 10 valids -> writes restart at addr 0, exactly one o_start.
REQ-036 output_size=1: single valid -> one write at addr 0, then o_start pulse.
